// File: rtl/ans_ltf_scheduler_if.sv
// LTF sample stream: data/valid/last, no backpressure.
// The consumer must accept every valid beat.
interface ans_ltf_scheduler_if;
  logic [31:0] data;
  logic        valid;
  logic        last;

  modport master (output data, valid, last);
  modport slave  (input  data, valid, last);
endinterface

// File: rtl/ans_ltf_scheduler.sv
// Per-packet sequencer for one ans_ht_ltf_generator: arm, precompute, grant, stream.
// Define ANS_LTF_TIMEOUT_EN to enable the wait-for-start watchdog.
module ans_ltf_scheduler #(
  parameter int PRECOMP_CYCLES = 96,
  parameter int LTF_LEN        = 80,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_coeff_wr,
  input  logic [127:0]   cfg_coeff,
  input  logic           pkt_start,
  input  logic           ltf_req,
  input  logic           abort,
  output logic           gen_reset,
  output logic           gen_letsgo,
  output logic           gen_givemeoutput,
  output logic [127:0]   gen_obf_coeff,
  input  logic [31:0]    gen_ltf_data,
  input  logic           gen_ltf_started,
  output logic           ltf_ready,
  ans_ltf_scheduler_if.master out,
  output logic           done,
  output logic           busy,
  output logic           err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PRECOMP,
    S_READY,
    S_WAITSTART,
    S_STREAM,
    S_DONE
  } state_t;

`ifdef ANS_LTF_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [6:0] PRE_LAST = 7'(PRECOMP_CYCLES - 1);
  localparam logic [6:0] LEN_LAST = 7'(LTF_LEN - 1);
  localparam logic [6:0] TO_LAST  = 7'(TIMEOUT_CYCLES - 1);

  state_t       state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [127:0] shadow_q, active_q;
  logic         err_q;
  logic         load;
  logic         kill;
  logic         to_hit;
  logic         valid;
  logic         last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cfg_coeff_wr)
        shadow_q <= cfg_coeff;
      // A write landing with pkt_start goes straight to the active copy.
      if (load)
        active_q <= cfg_coeff_wr ? cfg_coeff : shadow_q;
      if (to_hit)
        err_q <= 1'b1;
      else if (load)
        err_q <= 1'b0;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    load             = 1'b0;
    kill             = 1'b0;
    to_hit           = 1'b0;
    valid            = 1'b0;
    last             = 1'b0;
    gen_letsgo       = 1'b0;
    gen_givemeoutput = 1'b0;
    ltf_ready        = 1'b0;
    done             = 1'b0;
    if (abort && state_q != S_IDLE) begin
      kill    = 1'b1;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pkt_start) begin
            load    = 1'b1;
            state_d = S_ARM;
          end
        end
        S_ARM: begin
          gen_letsgo = 1'b1;
          cnt_d      = '0;
          state_d    = S_PRECOMP;
        end
        S_PRECOMP: begin
          if (cnt_q == PRE_LAST)
            state_d = S_READY;
          else
            cnt_d = cnt_q + 7'd1;
        end
        S_READY: begin
          ltf_ready = 1'b1;
          if (ltf_req) begin
            gen_givemeoutput = 1'b1;
            cnt_d            = '0;
            state_d          = S_WAITSTART;
          end
        end
        S_WAITSTART: begin
          if (gen_ltf_started) begin
            valid   = 1'b1;
            cnt_d   = 7'd1;
            state_d = S_STREAM;
          end else if (TO_EN && cnt_q == TO_LAST) begin
            to_hit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        S_STREAM: begin
          valid = 1'b1;
          if (cnt_q == LEN_LAST) begin
            last    = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign gen_reset     = reset | kill | to_hit;
  assign gen_obf_coeff = active_q;
  assign out.valid     = valid;
  assign out.last      = last;
  assign out.data      = valid ? gen_ltf_data : '0;
  assign busy          = state_q != S_IDLE;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_ans_ltf_scheduler.sv
// Randomized bench for ans_ltf_scheduler against a packet-timeline model.
// Build with ANS_LTF_TIMEOUT_EN to exercise the watchdog path.
module tb_ans_ltf_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_coeff_wr;
  logic [127:0] cfg_coeff;
  logic         pkt_start;
  logic         ltf_req;
  logic         abort;
  logic         gen_reset;
  logic         gen_letsgo;
  logic         gen_givemeoutput;
  logic [127:0] gen_obf_coeff;
  logic [31:0]  gen_ltf_data;
  logic         gen_ltf_started;
  logic         ltf_ready;
  logic         done;
  logic         busy;
  logic         err_timeout;

  int n_chk  = 0;
  int n_pass = 0;

  logic [127:0] m_shadow;
  logic [127:0] m_active;

  ans_ltf_scheduler_if so ();

  ans_ltf_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_coeff_wr     (cfg_coeff_wr),
    .cfg_coeff        (cfg_coeff),
    .pkt_start        (pkt_start),
    .ltf_req          (ltf_req),
    .abort            (abort),
    .gen_reset        (gen_reset),
    .gen_letsgo       (gen_letsgo),
    .gen_givemeoutput (gen_givemeoutput),
    .gen_obf_coeff    (gen_obf_coeff),
    .gen_ltf_data     (gen_ltf_data),
    .gen_ltf_started  (gen_ltf_started),
    .ltf_ready        (ltf_ready),
    .out              (so),
    .done             (done),
    .busy             (busy),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    pkt_start    = 1'b0;
    cfg_coeff_wr = 1'b0;
    abort        = 1'b0;
    gen_ltf_data = $urandom;
  endtask

  task automatic wr_cfg(input logic [127:0] v);
    cfg_coeff_wr = 1'b1;
    cfg_coeff    = v;
    m_shadow     = v;
  endtask

  task automatic start_pkt(input bit wr_same, input logic [127:0] v);
    pkt_start = 1'b1;
    if (wr_same) wr_cfg(v);
    m_active = m_shadow;
    settle;
    chk("idle_busy", busy, 0);
    adv;
    settle;
    chk("arm_letsgo", gen_letsgo, 1);
    chk("arm_coeff", gen_obf_coeff, m_active);
    chk("arm_busy", busy, 1);
    chk("arm_err", err_timeout, 0);
    adv;
  endtask

  task automatic precompute(input bit dup, input bit wr_mid,
                            input logic [127:0] v);
    int lg = 0;
    int rd = 0;
    int bz = 0;
    for (int i = 0; i < 96; i++) begin
      if (dup && i == 10) pkt_start = 1'b1;
      if (wr_mid && i == 20) wr_cfg(v);
      settle;
      lg += int'(gen_letsgo);
      rd += int'(ltf_ready);
      bz += int'(busy);
      adv;
    end
    chk("pre_letsgo", lg, 0);
    chk("pre_ready", rd, 0);
    chk("pre_busy", bz, 96);
    chk("pre_coeff", gen_obf_coeff, m_active);
  endtask

  task automatic grant(input int rdelay);
    for (int i = 0; i < rdelay; i++) begin
      settle;
      chk("rdy_wait", ltf_ready, 1);
      chk("rdy_give", gen_givemeoutput, 0);
      adv;
    end
    ltf_req = 1'b1;
    settle;
    chk("give", gen_givemeoutput, 1);
    chk("give_rdy", ltf_ready, 1);
    adv;
  endtask

  // Generator model: started for 64 samples, then 16 CP samples, new data each cycle.
  task automatic stream(input int gdelay, input int abort_at);
    for (int i = 0; i < gdelay; i++) begin
      settle;
      chk("ws_valid", so.valid, 0);
      chk("ws_busy", busy, 1);
      adv;
    end
    for (int s = 0; s <= 80; s++) begin
      gen_ltf_started = (s < 64);
      if (s == abort_at) abort = 1'b1;
      settle;
      if (s == abort_at) begin
        chk("ab_valid", so.valid, 0);
        chk("ab_last", so.last, 0);
        chk("ab_greset", gen_reset, 1);
        chk("ab_done", done, 0);
        adv;
        gen_ltf_started = 1'b0;
        settle;
        chk("ab_busy", busy, 0);
        chk("ab_done2", done, 0);
        chk("ab_valid2", so.valid, 0);
        adv;
        break;
      end
      chk("st_valid", so.valid, s < 80);
      if (s < 80) chk("st_data", so.data, gen_ltf_data);
      chk("st_last", so.last, s == 79);
      chk("st_done", done, s == 80);
      chk("st_greset", gen_reset, 0);
      adv;
    end
    gen_ltf_started = 1'b0;
    settle;
    chk("post_busy", busy, 0);
    chk("post_ready", ltf_ready, 0);
    chk("post_coeff", gen_obf_coeff, m_active);
    adv;
    ltf_req = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    cfg_coeff_wr    = 1'b0;
    cfg_coeff       = '0;
    pkt_start       = 1'b0;
    ltf_req         = 1'b0;
    abort           = 1'b0;
    gen_ltf_data    = '0;
    gen_ltf_started = 1'b0;
    m_shadow        = '0;
    m_active        = '0;

    @(posedge clk);
    #1;
    settle;
    chk("rst_greset", gen_reset, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    settle;
    chk("rst_greset_off", gen_reset, 0);
    chk("rst_letsgo", gen_letsgo, 0);
    chk("rst_give", gen_givemeoutput, 0);
    chk("rst_coeff", gen_obf_coeff, 0);
    chk("rst_ready", ltf_ready, 0);
    chk("rst_valid", so.valid, 0);
    chk("rst_last", so.last, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    adv;

    wr_cfg(128'hA5);
    settle;
    chk("shadow_only", gen_obf_coeff, 0);
    adv;

    start_pkt(1'b0, '0);
    precompute(1'b0, 1'b1, {4{32'hFFFF_FFFF}});
    grant(3);
    stream(2, -1);

    start_pkt(1'b0, '0);
    precompute(1'b1, 1'b0, '0);
    grant(0);
    stream(0, 40);

    start_pkt(1'b1, r128());
    precompute(1'b0, 1'b0, '0);
    grant(1);
    stream(1, 79);

    for (int p = 0; p < 10; p++) begin
      int ab;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 80)) : -1;
      if ($urandom_range(0, 1) == 1) begin
        wr_cfg(r128());
        settle;
        adv;
      end
      start_pkt(1'($urandom_range(0, 1)), r128());
      precompute(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r128());
      grant($urandom_range(0, 4));
      stream($urandom_range(0, 3), ab);
    end

    start_pkt(1'b0, '0);
    precompute(1'b0, 1'b0, '0);
    grant(0);
`ifdef ANS_LTF_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      settle;
      chk("to_greset", gen_reset, i == 7);
      chk("to_err", err_timeout, 0);
      chk("to_busy", busy, 1);
      adv;
    end
    settle;
    chk("to_err_set", err_timeout, 1);
    chk("to_idle", busy, 0);
    chk("to_done", done, 0);
    adv;
    ltf_req = 1'b0;
    start_pkt(1'b0, '0);
    abort = 1'b1;
    settle;
    chk("to_abort", gen_reset, 1);
    adv;
`else
    for (int i = 0; i < 20; i++) begin
      settle;
      chk("wait_busy", busy, 1);
      chk("wait_err", err_timeout, 0);
      chk("wait_greset", gen_reset, 0);
      adv;
    end
    ltf_req = 1'b0;
    abort = 1'b1;
    settle;
    chk("wait_abort", gen_reset, 1);
    adv;
`endif
    settle;
    chk("end_busy", busy, 0);
    abort = 1'b1;
    settle;
    chk("idle_abort", gen_reset, 0);
    adv;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
